// File: rtl/pwm_decode.sv
// PWM duty decoder: measures high time per fixed-length window and recovers
// a debounced fade direction (ramping up/down or holding high/low).
module pwm_decode #(
    parameter int unsigned PWM_INTERVAL   = 1200,
    parameter int unsigned DEADBAND       = 3,
    parameter int unsigned STABLE_WINDOWS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pwm_in,
    output logic [$clog2(PWM_INTERVAL)-1:0] duty_value,
    output logic                            duty_valid,
    output logic [1:0]                      state_out,
    output logic                            state_valid
);

    localparam int unsigned DW = $clog2(PWM_INTERVAL);
    localparam int unsigned CW = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned EW = CW + 1;
    localparam int unsigned MW = $clog2(STABLE_WINDOWS + 1);

    typedef enum logic [1:0] {
        ST_INC  = 2'b00,
        ST_DEC  = 2'b01,
        ST_HIGH = 2'b10,
        ST_LOW  = 2'b11
    } fade_e;

    logic [1:0]    sync_q;
    logic          pwm_s;
    logic [DW-1:0] win_cnt, win_nxt;
    logic [CW-1:0] high_cnt, high_nxt;
    logic [DW-1:0] ref_q, ref_nxt;
    logic          ref_valid, ref_valid_nxt;
    fade_e         pend_q, pend_nxt;
    logic [MW-1:0] match_cnt, match_nxt, match_new;
    fade_e         state_q, state_nxt;
    logic          state_valid_nxt;
    logic [DW-1:0] duty_nxt;
    logic          duty_valid_nxt;

    logic          win_end;
    logic [EW-1:0] sum_e;
    logic [DW-1:0] v;
    logic [EW-1:0] v_e, ref_e;
    logic          cls_hit;
    fade_e         cls;

    assign pwm_s     = sync_q[1];
    assign state_out = state_q;

    // Two-flop synchronizer for the asynchronous PWM input
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], pwm_in};
    end

    // Window-end value (clamped) and its classification against the reference
    always_comb begin
        win_end = (win_cnt == DW'(PWM_INTERVAL - 1));
        sum_e   = EW'(high_cnt) + EW'(pwm_s);
        v       = (sum_e > EW'(PWM_INTERVAL - 1)) ? DW'(PWM_INTERVAL - 1) : sum_e[DW-1:0];
        v_e     = EW'(v);
        ref_e   = EW'(ref_q);
        cls_hit = 1'b1;
        cls     = ST_LOW;
        if (v_e >= EW'(PWM_INTERVAL - 1 - DEADBAND))  cls = ST_HIGH;
        else if (v_e <= EW'(DEADBAND))                cls = ST_LOW;
        else if (v_e > ref_e + EW'(DEADBAND))         cls = ST_INC;
        else if (v_e + EW'(DEADBAND) < ref_e)         cls = ST_DEC;
        else                                          cls_hit = 1'b0;
    end

    // Next-state: window counting, duty capture, reference and debounce
    always_comb begin
        win_nxt         = win_cnt + DW'(1);
        high_nxt        = high_cnt + CW'(pwm_s);
        duty_nxt        = duty_value;
        duty_valid_nxt  = 1'b0;
        ref_nxt         = ref_q;
        ref_valid_nxt   = ref_valid;
        pend_nxt        = pend_q;
        match_nxt       = match_cnt;
        match_new       = match_cnt;
        state_nxt       = state_q;
        state_valid_nxt = state_valid;
        if (win_end) begin
            win_nxt        = '0;
            high_nxt       = '0;
            duty_nxt       = v;
            duty_valid_nxt = 1'b1;
            if (!ref_valid) begin
                ref_nxt       = v;
                ref_valid_nxt = 1'b1;
            end else if (cls_hit) begin
                ref_nxt = v;
                if (cls == pend_q) begin
                    match_new = (match_cnt == MW'(STABLE_WINDOWS)) ? match_cnt
                                                                   : match_cnt + MW'(1);
                end else begin
                    pend_nxt  = cls;
                    match_new = MW'(1);
                end
                match_nxt = match_new;
                if (match_new == MW'(STABLE_WINDOWS)) begin
                    state_nxt       = cls;
                    state_valid_nxt = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            high_cnt    <= '0;
            duty_value  <= '0;
            duty_valid  <= 1'b0;
            ref_q       <= '0;
            ref_valid   <= 1'b0;
            pend_q      <= ST_INC;
            match_cnt   <= '0;
            state_q     <= ST_LOW;
            state_valid <= 1'b0;
        end else begin
            win_cnt     <= win_nxt;
            high_cnt    <= high_nxt;
            duty_value  <= duty_nxt;
            duty_valid  <= duty_valid_nxt;
            ref_q       <= ref_nxt;
            ref_valid   <= ref_valid_nxt;
            pend_q      <= pend_nxt;
            match_cnt   <= match_nxt;
            state_q     <= state_nxt;
            state_valid <= state_valid_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_decode.sv
// Randomized self-checking bench for pwm_decode with a window-sum reference model.
module tb_pwm_decode;

    localparam int P  = 1200;
    localparam int DB = 3;
    localparam int SW = 2;
    localparam int DW = $clog2(P);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [DW-1:0] duty_value;
    logic          duty_valid;
    logic [1:0]    state_out;
    logic          state_valid;

    pwm_decode #(.PWM_INTERVAL(P), .DEADBAND(DB), .STABLE_WINDOWS(SW)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .duty_value(duty_value), .duty_valid(duty_valid),
        .state_out(state_out), .state_valid(state_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit hist[$];
    int m_n, m_last, m_ref, m_ref_valid, m_pend, m_cnt, m_state, m_sv;
    int dl[0:15];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_n = 0; m_last = 0; m_ref = 0; m_ref_valid = 0;
        m_pend = 0; m_cnt = 0; m_state = 3; m_sv = 0;
    endtask

    // Apply one completed window value to the classification/debounce model
    task automatic model_window(input int v);
        int cls;
        if (m_ref_valid == 0) begin
            m_ref = v; m_ref_valid = 1;
        end else begin
            if (v >= P - 1 - DB)     cls = 2;
            else if (v <= DB)        cls = 3;
            else if (v > m_ref + DB) cls = 0;
            else if (v + DB < m_ref) cls = 1;
            else                     cls = -1;
            if (cls >= 0) begin
                m_ref = v;
                if (cls == m_pend) m_cnt = (m_cnt + 1 > SW) ? SW : m_cnt + 1;
                else begin m_pend = cls; m_cnt = 1; end
                if (m_cnt == SW) begin m_state = m_pend; m_sv = 1; end
            end
        end
    endtask

    function automatic bit pat(input int mode, input int n, input int ph);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((n + ph) % P) < 300;
            3: return (n / P < 16) ? ((n % P) < dl[n / P]) : 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Pulse reset for one edge; outputs must read reset values right after it
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_duty_value", int'(duty_value), 0);
        check("rst_duty_valid", int'(duty_valid), 0);
        check("rst_state_out", int'(state_out), 3);
        check("rst_state_valid", int'(state_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drive ncyc cycles from the current negedge, checking every cycle
    task automatic run(input int mode, input int ncyc, input int ph);
        for (int i = 0; i < ncyc; i++) begin
            bit b;
            b = pat(mode, m_n, ph);
            pwm_in = b;
            hist.push_back(b);
            @(posedge clk); #1;
            if ((m_n % P) == P - 1) begin
                int sum;
                sum = 0;
                for (int e = m_n - (P - 1); e <= m_n; e++)
                    if (e >= 2) sum += int'(hist[e - 2]);
                if (sum > P - 1) sum = P - 1;
                m_last = sum;
                model_window(sum);
                check("pulse_duty_valid", int'(duty_valid), 1);
                check("duty_value", int'(duty_value), m_last);
                check("state_out", int'(state_out), m_state);
                check("state_valid", int'(state_valid), m_sv);
            end else begin
                check("idle_duty_valid", int'(duty_valid), 0);
                check("hold_duty_value", int'(duty_value), m_last);
            end
            m_n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int base, dir, phs[4];
        phs = '{0, 137, 650, 1101};
        model_reset();
        repeat (3) @(negedge clk);

        // Input held low: LOW_HOLD commits on third pulse
        do_reset();
        run(0, 4 * P, 0);
        check("low_hold_state_valid", m_sv, 1);

        // Input held high: clamp to P-1, HIGH_HOLD
        do_reset();
        run(1, 4 * P, 0);
        check("high_clamp_value", int'(duty_value), P - 1);
        check("high_hold_state", int'(state_out), 2);

        // Periodic 300-high waveform at several phases
        foreach (phs[i]) begin
            do_reset();
            run(2, 3 * P, phs[i]);
            check("phase_duty_300", int'(duty_value), 300);
        end

        // Ramp 600,606,612,618 commits INC on the 612 window
        dl[0] = 600; dl[1] = 606; dl[2] = 612; dl[3] = 618;
        do_reset();
        run(3, 3 * P, 0);
        check("ramp_commit_inc", int'(state_out), 0);
        run(3, P, 0);

        // Single +6 then -6 between holds: no commit
        dl[0] = 600; dl[1] = 600; dl[2] = 606; dl[3] = 600; dl[4] = 600; dl[5] = 600;
        do_reset();
        run(3, 6 * P, 0);
        check("blip_no_commit", int'(state_valid), 0);

        // Random-walk duty sequences
        for (int r = 0; r < 2; r++) begin
            base = $urandom_range(100, 1100);
            dir  = ($urandom_range(0, 1) == 0) ? -1 : 1;
            for (int k = 0; k < 6; k++) begin
                dl[k] = base;
                base  = base + dir * $urandom_range(0, 10);
                if (base < 0) base = 0;
                if (base > P - 1) base = P - 1;
            end
            do_reset();
            run(3, 6 * P, 0);
        end

        // Random bit stream
        do_reset();
        run(4, 2 * P, 0);

        // Mid-window reset at window count 500 with input high
        do_reset();
        run(1, 3 * P + 500, 0);
        do_reset();
        run(1, 2 * P, 0);
        check("post_rst_second_window", int'(duty_value), P - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
